// File: rtl/tff_bank_sequencer.sv
// Sequencer driving the toggle enables of an external T flip-flop bank so it
// steps modulo a terminal value, up or down, with optional pre-clear, pause and done pulse.
module tff_bank_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             SR,
  input  logic             start,
  input  logic             dir,
  input  logic             clr_first,
  input  logic [WIDTH-1:0] limit,
  input  logic [CNT_W-1:0] steps,
  input  logic             pause,
  input  logic [WIDTH-1:0] Q_fb,
  output logic [WIDTH-1:0] T,
  output logic             clr,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               dir_q, dir_d;
  logic               clr_first_q, clr_first_d;
  logic [WIDTH-1:0]   limit_q, limit_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;

  logic [WIDTH-1:0]   next_val;
  logic               wrap_sel;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge Clk) begin
    if (SR) begin
      state_q     <= IDLE;
      dir_q       <= 1'b0;
      clr_first_q <= 1'b0;
      limit_q     <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      clr_first_q <= clr_first_d;
      limit_q     <= limit_d;
      remaining_q <= remaining_d;
    end
  end

  // Out-of-range bank values are folded back into range as a wrap.
  always_comb begin
    if (!dir_q) begin
      wrap_sel = (Q_fb >= limit_q);
      next_val = wrap_sel ? '0 : Q_fb + 1'b1;
    end else begin
      wrap_sel = (Q_fb == '0) || (Q_fb > limit_q);
      next_val = wrap_sel ? limit_q : Q_fb - 1'b1;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    clr_first_d = clr_first_q;
    limit_d     = limit_q;
    remaining_d = remaining_q;
    T           = '0;
    clr         = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    wrap        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          dir_d       = dir;
          clr_first_d = clr_first;
          limit_d     = limit;
          remaining_d = steps;
          if (steps == '0)    state_d = DONE;
          else if (clr_first) state_d = CLEAR;
          else                state_d = RUN;
        end
      end
      CLEAR: begin
        clr     = clr_first_q;
        busy    = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (!pause) begin
          T           = Q_fb ^ next_val;
          wrap        = wrap_sel;
          remaining_d = remaining_q - 1'b1;
          // RUN is only entered with a non-zero count, so this stops at zero.
          if (remaining_q == {{(CNT_W-1){1'b0}}, 1'b1}) state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (SR) begin
      T    = '0;
      clr  = 1'b0;
      busy = 1'b0;
      done = 1'b0;
      wrap = 1'b0;
    end
  end

endmodule

// File: tb/tb_tff_bank_sequencer.sv
// Scoreboard bench: tests push expected per-cycle outputs, a negedge monitor
// pops and compares whenever the sequencer shows any activity.
module tb_tff_bank_sequencer;

  logic       Clk = 1'b0;
  logic       SR;
  logic       start;
  logic       dir;
  logic       clr_first;
  logic [3:0] limit;
  logic [7:0] steps;
  logic       pause;
  logic [3:0] Q_fb;
  logic [3:0] T;
  logic       clr;
  logic       busy;
  logic       done;
  logic       wrap;

  logic [3:0] bank_q;
  logic       load_en;
  logic [3:0] load_val;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [3:0] t;
    logic       clr;
    logic       busy;
    logic       done;
    logic       wrap;
    logic [3:0] q;
  } rec_t;

  rec_t exp_q[$];

  always #5 Clk = ~Clk;

  tff_bank_sequencer #(.WIDTH(4), .CNT_W(8)) dut (
    .Clk       (Clk),
    .SR        (SR),
    .start     (start),
    .dir       (dir),
    .clr_first (clr_first),
    .limit     (limit),
    .steps     (steps),
    .pause     (pause),
    .Q_fb      (Q_fb),
    .T         (T),
    .clr       (clr),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  // External T flip-flop bank with synchronous clear, plus a bench preload path.
  always @(posedge Clk) begin
    if (load_en)  bank_q <= load_val;
    else if (clr) bank_q <= '0;
    else          bank_q <= bank_q ^ T;
  end
  assign Q_fb = bank_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if ((|T) || clr || busy || done || wrap) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output {T,clr,busy,done,wrap}", {23'd0, T, clr, busy, done, wrap}, 32'd0);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        check("record {T,clr,busy,done,wrap,Q}", {19'd0, T, clr, busy, done, wrap, Q_fb}, {19'd0, e});
      end
    end
  end

  task automatic push_rec(input logic [3:0] t, input logic c, input logic b,
                          input logic d, input logic w, input logic [3:0] q);
    rec_t r;
    r = '{t: t, clr: c, busy: b, done: d, wrap: w, q: q};
    exp_q.push_back(r);
  endtask

  task automatic push_step(input logic [3:0] from, input logic [3:0] to, input logic w);
    push_rec(from ^ to, 1'b0, 1'b1, 1'b0, w, from);
  endtask

  task automatic push_done(input logic [3:0] q);
    push_rec(4'h0, 1'b0, 1'b0, 1'b1, 1'b0, q);
  endtask

  task automatic preload(input logic [3:0] v);
    load_en  = 1'b1;
    load_val = v;
    @(posedge Clk);
    #1 load_en = 1'b0;
  endtask

  task automatic launch(input logic d, input logic cf, input logic [3:0] lim, input logic [7:0] st);
    dir       = d;
    clr_first = cf;
    limit     = lim;
    steps     = st;
    start     = 1'b1;
    @(posedge Clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 600 && !seen; n++) begin
      @(negedge Clk);
      if (done) seen = 1'b1;
    end
    check(name, {31'd0, seen}, 32'd1);
    @(posedge Clk);
    #1;
  endtask

  logic [3:0] seq_up   [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1, 4'd2};
  logic [3:0] seq_down [4] = '{4'd1, 4'd0, 4'd9, 4'd8};
  logic [3:0] seq_oor  [4] = '{4'd7, 4'd0, 4'd1, 4'd2};
  logic [3:0] seq_full [11] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13};

  initial begin
    SR = 1'b1; start = 1'b0; dir = 1'b0; clr_first = 1'b0;
    limit = '0; steps = '0; pause = 1'b0;
    load_en = 1'b1; load_val = '0;

    // Reset state
    repeat (2) begin
      @(negedge Clk);
      check("reset_outputs", {27'd0, T, clr, busy, done, wrap}, 32'd0);
    end
    @(posedge Clk);
    #1 SR = 1'b0; load_en = 1'b0;

    // Up with clear, pause held through CLEAR does not delay it
    preload(4'd3);
    push_rec(4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3);
    for (int i = 0; i < 8; i++) push_step(seq_up[i], seq_up[i+1], seq_up[i] == 4'd5);
    push_done(4'd2);
    pause = 1'b1;
    launch(1'b0, 1'b1, 4'd5, 8'd8);
    @(posedge Clk);
    #1 pause = 1'b0;
    wait_done("up_clear_done");

    // Down without clear
    preload(4'd1);
    for (int i = 0; i < 3; i++) push_step(seq_down[i], seq_down[i+1], seq_down[i] == 4'd0);
    push_done(4'd8);
    launch(1'b1, 1'b0, 4'd9, 8'd3);
    wait_done("down_done");

    // Pause two cycles with bank out of range
    preload(4'd7);
    push_rec(4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7);
    push_rec(4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7);
    for (int i = 0; i < 3; i++) push_step(seq_oor[i], seq_oor[i+1], seq_oor[i] == 4'd7);
    push_done(4'd2);
    pause = 1'b1;
    launch(1'b0, 1'b0, 4'd5, 8'd3);
    @(posedge Clk);
    #1;
    @(posedge Clk);
    #1 pause = 1'b0;
    wait_done("pause_done");

    // Zero steps: done only, even with clear requested
    push_done(4'd2);
    launch(1'b0, 1'b1, 4'd5, 8'd0);
    wait_done("zero_steps_done");

    // Reset at step 4 of 10, starts during reset ignored
    preload(4'd0);
    push_step(4'd0, 4'd1, 1'b0);
    push_step(4'd1, 4'd2, 1'b0);
    push_step(4'd2, 4'd3, 1'b0);
    launch(1'b0, 1'b0, 4'd15, 8'd10);
    @(posedge Clk);
    #1;
    @(posedge Clk);
    #1;
    @(posedge Clk);
    #1 SR = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start = (i != 1);
      @(negedge Clk);
      check("sr_outputs", {27'd0, T, clr, busy, done, wrap}, 32'd0);
      @(posedge Clk);
      #1;
    end
    SR = 1'b0; start = 1'b0;
    repeat (4) @(posedge Clk);
    #1 check("bank_after_reset", {28'd0, bank_q}, 32'd3);
    for (int i = 0; i < 10; i++) push_step(seq_full[i], seq_full[i+1], 1'b0);
    push_done(4'd13);
    launch(1'b0, 1'b0, 4'd15, 8'd10);
    wait_done("after_reset_done");

    // Start held high: ignored in RUN, restarts with new inputs after DONE
    preload(4'd0);
    push_step(4'd0, 4'd1, 1'b0);
    push_step(4'd1, 4'd2, 1'b0);
    push_done(4'd2);
    push_step(4'd2, 4'd1, 1'b0);
    push_done(4'd1);
    dir = 1'b0; clr_first = 1'b0; limit = 4'd3; steps = 8'd2; start = 1'b1;
    @(posedge Clk);
    #1 dir = 1'b1; steps = 8'd1;
    wait_done("held_start_first_done");
    @(posedge Clk);
    #1 start = 1'b0;
    wait_done("held_start_second_done");

    // Maximum count issues exactly 255 steps
    preload(4'd0);
    for (int i = 0; i < 255; i++) begin
      logic [3:0] f;
      logic [3:0] t;
      f = 4'(i % 16);
      t = 4'((i + 1) % 16);
      push_step(f, t, f == 4'd15);
    end
    push_done(4'd15);
    launch(1'b0, 1'b0, 4'd15, 8'd255);
    wait_done("max_steps_done");

    repeat (3) @(posedge Clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tff_bank_sequencer.md
TFF_BANK_SEQUENCER -- requirements
Module: tff_bank_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the width of the controlled T flip-flop bank.
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of the step-count input.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Port Clk, input, 1, is the rising-edge clock for all state.
REQ-005 Port SR, input, 1, is the synchronous active-high reset.
REQ-006 Port start, input, 1, requests a sequence; it is sampled only in IDLE.
REQ-007 Port dir, input, 1, selects direction: 0 = up, 1 = down; it is latched on accepted start.
REQ-008 Port clr_first, input, 1, requests a bank clear before stepping; it is latched on accepted start.
REQ-009 Port limit, input, WIDTH, is the modulo terminal value; it is latched on accepted start.
REQ-010 Port steps, input, CNT_W, is the number of steps to issue; it is latched on accepted start.
REQ-011 Port pause, input, 1, holds the sequence while high; it is evaluated live.
REQ-012 Port Q_fb, input, WIDTH, carries the Q outputs of the external T flip-flop bank.
REQ-013 Port T, output, WIDTH, carries the toggle enables to the bank.
REQ-014 Port clr, output, 1, drives the SR input of the bank.
REQ-015 Port busy, output, 1, is high in CLEAR and RUN.
REQ-016 Port done, output, 1, is a one-cycle completion pulse.
REQ-017 Port wrap, output, 1, is high in any step cycle whose next value wraps.

Function
REQ-018 The FSM SHALL have states IDLE, CLEAR, RUN and DONE.
REQ-019 IDLE with start=1: latch dir, clr_first, limit and steps; then go to DONE if steps==0, else CLEAR if clr_first=1, else RUN.
REQ-020 CLEAR SHALL assert clr=1 for exactly one cycle with T=0, then go to RUN.
REQ-021 RUN SHALL compute next per cycle, combinationally from Q_fb.
- Up: next = 0 if Q_fb >= limit, otherwise Q_fb+1.
- Down: next = limit if Q_fb==0 or Q_fb > limit, otherwise Q_fb-1.
REQ-022 In RUN with pause=0, T SHALL equal Q_fb XOR next, so the bank holds next after the following edge (latency one clock per step).
REQ-023 wrap SHALL be high, combinationally, in a RUN cycle with pause=0 whenever next was selected by a wrap or out-of-range term in REQ-021.
REQ-024 In RUN with pause=1, T SHALL be 0, wrap SHALL be 0 and the remaining-step count SHALL hold.
REQ-025 Each unpaused RUN cycle SHALL decrement the remaining count; the cycle issuing the last step SHALL transition to DONE.
REQ-026 DONE SHALL assert done=1 for one cycle with T=0, then return to IDLE.
REQ-027 start SHALL be ignored outside IDLE; start held high through DONE starts a new sequence from the following IDLE cycle.
REQ-028 T, clr and wrap SHALL be 0 in IDLE and DONE.
REQ-029 The remaining-step counter SHALL never underflow; steps = 2^CNT_W-1 SHALL issue exactly that many steps.
REQ-030 pause asserted in CLEAR SHALL NOT delay the clear; it takes effect from the first RUN cycle.

Reset
REQ-031 SR=1 at a rising edge SHALL force IDLE and clear the remaining count and all latched inputs to 0.
REQ-032 While SR=1, T, clr, busy, done and wrap SHALL be 0, including mid-sequence.
REQ-033 After SR deasserts, the block SHALL start only on a new start in IDLE.

Verification
REQ-034 Up clear run: limit=5, steps=8, dir=0, clr_first=1, bank Q=3.
- Required: clr for 1 cycle; Q sequence 1,2,3,4,5,0,1,2.
- Required: wrap on the step 5->0; done one cycle after the last step.
REQ-035 Down run without clear: Q=1, limit=9, steps=3, dir=1, clr_first=0.
- Required: Q 0,9,8; wrap on the 0->9 step.
- Required: busy high for 3 cycles.
REQ-036 Pause and out-of-range: pause for 2 cycles mid-RUN with Q=7, limit=5, up.
- Required: T=0 during the pause.
- Required: next step gives Q=0 with wrap=1; total steps unchanged.
REQ-037 steps=0: start yields done one cycle later, with busy, T and clr never asserted.
REQ-038 Reset mid-run: SR at step 4 of 10.
- Required: all outputs 0 next cycle; start pulses during SR are ignored.
- Required: a fresh start afterwards runs a full count.
REQ-039 Start during RUN is ignored; start held high completes, then restarts with the newly latched inputs.
